// File: rtl/rom_port_arbiter.sv
// Two-port ROM read arbiter: up to two requesters served per cycle, round-robin.
// Define ROM_ARB_FIXED_PRIO_EN to use fixed lowest-index-first priority instead.
module rom_port_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*ADDR_WIDTH-1:0]   req_addr,
    output logic [NREQ-1:0]              gnt,
    output logic [NREQ-1:0]              rsp_valid,
    output logic [NREQ*DATA_WIDTH-1:0]   rsp_data,
    output logic [ADDR_WIDTH-1:0]        rom_addr_a,
    output logic [ADDR_WIDTH-1:0]        rom_addr_b,
    output logic                         rom_en_a,
    output logic                         rom_en_b,
    input  logic [DATA_WIDTH-1:0]        rom_data_a,
    input  logic [DATA_WIDTH-1:0]        rom_data_b
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] base;
    logic [IW-1:0] idx_a;
    logic [IW-1:0] idx_b;
    logic          found_a;
    logic          found_b;

`ifdef ROM_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [IW-1:0] ptr;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        if (int'(i) == NREQ - 1) return '0;
        return i + IW'(1);
    endfunction

    assign base = ptr;

    // Pointer moves past the last index served this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (rom_en_b) begin
            ptr <= wrap_inc(idx_b);
        end else if (rom_en_a) begin
            ptr <= wrap_inc(idx_a);
        end
    end
`endif

    // Circular scan from base: first hit goes to port A, second to port B.
    always_comb begin
        int j;
        found_a = 1'b0;
        found_b = 1'b0;
        idx_a   = '0;
        idx_b   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(base) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req[j] && !found_a) begin
                found_a = 1'b1;
                idx_a   = IW'(j);
            end else if (req[j] && !found_b) begin
                found_b = 1'b1;
                idx_b   = IW'(j);
            end
        end
    end

    assign rom_en_a = found_a & ~reset;
    assign rom_en_b = found_b & ~reset;

    always_comb begin
        gnt        = '0;
        rom_addr_a = '0;
        rom_addr_b = '0;
        if (rom_en_a) begin
            gnt[idx_a] = 1'b1;
            rom_addr_a = req_addr[int'(idx_a)*ADDR_WIDTH +: ADDR_WIDTH];
        end
        if (rom_en_b) begin
            gnt[idx_b] = 1'b1;
            rom_addr_b = req_addr[int'(idx_b)*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Ungranted slices keep their previous data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= gnt;
            if (rom_en_a)
                rsp_data[int'(idx_a)*DATA_WIDTH +: DATA_WIDTH] <= rom_data_a;
            if (rom_en_b)
                rsp_data[int'(idx_b)*DATA_WIDTH +: DATA_WIDTH] <= rom_data_b;
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: reference model predicts grants and
// queues expected responses; a monitor pops them as the DUT presents rsp_valid.
module tb_rom_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 4;

    typedef struct {
        logic [N-1:0]    mask;
        logic [N*DW-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rsp_valid;
    logic [N*DW-1:0]   rsp_data;
    logic [AW-1:0]     rom_addr_a, rom_addr_b;
    logic              rom_en_a, rom_en_b;
    logic [DW-1:0]     rom_data_a, rom_data_b;

    int vectors = 0;
    int errors  = 0;
    exp_t q[$];
    logic [DW-1:0] shadow[N];
    int mptr = 0;
    logic [N-1:0] pend = '0;
    logic [AW-1:0] paddr[N];

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] x);
        int v;
        v = int'(x) * int'(x) + int'(x);
        return DW'(v);
    endfunction

    assign rom_data_a = rom_f(rom_addr_a);
    assign rom_data_b = rom_f(rom_addr_b);

    always #5 clk = ~clk;

    rom_port_arbiter #(.NREQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rom_addr_a(rom_addr_a), .rom_addr_b(rom_addr_b),
        .rom_en_a(rom_en_a), .rom_en_b(rom_en_b),
        .rom_data_a(rom_data_a), .rom_data_b(rom_data_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*DW-1:0] flat_shadow();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = shadow[i];
        return v;
    endfunction

    // Drive one request cycle and predict its outcome from the arbitration rules.
    task automatic cycle(input logic [N-1:0] r, input logic [N*AW-1:0] a,
                         output logic [N-1:0] eg);
        int order[$];
        int s, i, last;
        logic [AW-1:0] ea, eb;
        logic ena, enb;
        @(negedge clk);
        req = r;
        req_addr = a;
        #1;
`ifdef ROM_ARB_FIXED_PRIO_EN
        s = 0;
`else
        s = mptr;
`endif
        for (int k = 0; k < N; k++) begin
            i = (s + k) % N;
            if (r[i]) order.push_back(i);
        end
        eg = '0; ea = '0; eb = '0; ena = 1'b0; enb = 1'b0; last = -1;
        if (order.size() > 0) begin
            eg[order[0]] = 1'b1; ena = 1'b1;
            ea = a[order[0]*AW +: AW];
            shadow[order[0]] = rom_f(ea);
            last = order[0];
        end
        if (order.size() > 1) begin
            eg[order[1]] = 1'b1; enb = 1'b1;
            eb = a[order[1]*AW +: AW];
            shadow[order[1]] = rom_f(eb);
            last = order[1];
        end
        if (last >= 0) mptr = (last + 1) % N;
        chk("gnt", 64'(gnt), 64'(eg));
        chk("rom_en", 64'({rom_en_a, rom_en_b}), 64'({ena, enb}));
        chk("rom_addr", 64'({rom_addr_a, rom_addr_b}), 64'({ea, eb}));
        if (eg != '0) q.push_back('{mask: eg, data: flat_shadow()});
    endtask

    // Monitor: every presented response must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && rsp_valid != '0) begin
                if (q.size() == 0) begin
                    chk("spurious_rsp_valid", 64'(rsp_valid), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("rsp_valid", 64'(rsp_valid), 64'(e.mask));
                    chk("rsp_data", 64'(rsp_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        logic [N-1:0] eg;
        logic [N*AW-1:0] a;
        for (int i = 0; i < N; i++) shadow[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt", 64'(gnt), 64'(0));
        chk("reset_en", 64'({rom_en_a, rom_en_b}), 64'(0));
        chk("reset_addr", 64'({rom_addr_a, rom_addr_b}), 64'(0));
        chk("reset_rsp", 64'({rsp_valid, rsp_data}), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // single requester, addr 3 -> 0x0C on port A only
        a = '0; a[0*AW +: AW] = 4'd3;
        cycle(4'b0001, a, eg);
        cycle(4'b0000, a, eg);
        chk("slice0_c", 64'(rsp_data[0 +: DW]), 64'h0C);

        // two requesters in one cycle
        a = '0; a[1*AW +: AW] = 4'd5; a[2*AW +: AW] = 4'd15;
        cycle(4'b0110, a, eg);
        cycle(4'b0000, a, eg);
        chk("slice1_1e", 64'(rsp_data[1*DW +: DW]), 64'h1E);
        chk("slice2_f0", 64'(rsp_data[2*DW +: DW]), 64'hF0);

        // wraparound pair from pointer 3
        a = '0; a[3*AW +: AW] = 4'd2; a[0*AW +: AW] = 4'd7;
        cycle(4'b1001, a, eg);
`ifndef ROM_ARB_FIXED_PRIO_EN
        chk("wrap_gnt_1001", 64'(gnt), 64'(4'b1001));
`endif

        // reset in the cycle after a grant discards everything
        @(posedge clk);
        #2;
        reset = 1'b1;
        req = '0;
        #1;
        chk("midreset_rsp", 64'({rsp_valid, rsp_data}), 64'(0));
        chk("midreset_gnt", 64'(gnt), 64'(0));
        q.delete();
        mptr = 0;
        for (int i = 0; i < N; i++) shadow[i] = '0;
        @(negedge clk);
        reset = 1'b0;
        a = '0; a[1*AW +: AW] = 4'd9;
        cycle(4'b0000, a, eg);
        cycle(4'b0010, a, eg);
        chk("post_reset_gnt", 64'(gnt), 64'(4'b0010));

        // all requesting continuously; same address on every slice
        a = {N{4'd6}};
        repeat (4) cycle(4'b1111, a, eg);
        cycle(4'b0000, a, eg);

        // randomized: each requester holds its request until granted
        for (int i = 0; i < N; i++) paddr[i] = '0;
        for (int t = 0; t < 400; t++) begin
            logic [N-1:0] r;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    paddr[i] = AW'($urandom);
                end
                a[i*AW +: AW] = paddr[i];
            end
            r = pend;
            cycle(r, a, eg);
            pend = pend & ~eg;
        end
        cycle(4'b0000, a, eg);
        repeat (3) cycle(4'b0000, a, eg);
        chk("queue_drained", 64'(q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
